load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter V, default 32: data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for bus_ack.
REQ-003 SHALL have clk, input, 1: the single clock.
REQ-004 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have mem_read_m, input, 1: load request from the CPU memory stage.
REQ-006 SHALL have Mem_write_m, input, 1: store request from the CPU memory stage.
REQ-007 SHALL have wrdata_add, input, V: byte address.
REQ-008 SHALL have wrdata, input, V: store data, right-aligned.
REQ-009 SHALL have funct_3m, input, 4: bits [2:0] select the access type; bit 3 is ignored.
REQ-010 SHALL have read_data, output, V: extended load result returned to the CPU.
REQ-011 SHALL have stall, output, 1: freezes the CPU pipeline while an access is in flight.
REQ-012 SHALL have misalign, output, 1: one-cycle pulse flagging a misaligned access.
REQ-013 SHALL have bus_err, output, 1: one-cycle pulse flagging an ack timeout.
REQ-014 SHALL have bus_req, output, 1; bus_we, output, 1; bus_addr, output, V (word-aligned); bus_wdata, output, V; bus_be, output, 4.
REQ-015 SHALL have bus_rdata, input, V, and bus_ack, input, 1.

Function
REQ-016 SHALL implement an FSM with states IDLE, REQ and DONE.
REQ-017 In IDLE, a request is mem_read_m or Mem_write_m. If both are high, the access is a store.
REQ-018 Alignment: a halfword access (funct3 x01) with addr[0]=1 is misaligned; a word access (x10 or x11) with addr[1:0]!=0 is misaligned.
- In that cycle misalign=1 and stall=0.
- No bus access is made and the state stays IDLE.
REQ-019 For an aligned request in IDLE:
- stall=1 combinationally in the same cycle.
- Register {addr[V-1:2],2'b00}, byte offset, funct3, we, lane-shifted data and be.
- Next state REQ.
REQ-020 Byte enables: SB gives be=4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111. Store data is shifted left by 8*addr[1:0].
REQ-021 In REQ:
- bus_req=1, stall=1, and all bus_* outputs are held stable.
- A 0-based wait counter increments each cycle without bus_ack.
REQ-022 bus_ack=1 in REQ captures bus_rdata and moves to DONE. An ack in the same cycle as REQ entry is not possible, because bus_req is registered.
REQ-023 If the counter reaches TIMEOUT with no ack: bus_err=1 for one cycle, read_data=0, go to DONE.
REQ-024 In DONE:
- stall=0 and read_data is valid for that cycle.
- Next state IDLE; a new request may be accepted in the following cycle.
REQ-025 Load extension, after shifting right by 8*offset:
- LB (000) sign-extends bit 7; LH (001) sign-extends bit 15.
- LW (010) passes through.
- LBU (100) and LHU (101) zero-extend.
- 011, 110 and 111 are treated as LW.
REQ-026 read_data holds its last value outside DONE. For a store, read_data is unchanged.
REQ-027 bus_ack received in IDLE or DONE SHALL be ignored.
REQ-028 Minimum access latency is 3 cycles (accept, REQ with ack, DONE). stall is high for exactly 1+N cycles, where N is the number of REQ cycles.

Reset
REQ-029 On reset=1 at a clk edge:
- State goes to IDLE; the counter is cleared.
- read_data=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
- misalign=0, bus_err=0.
REQ-030 Reset during REQ SHALL abort the access: bus_req drops on the next cycle, and no error or data is reported.

Structure
REQ-031 A shared package SHALL hold:
- the funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
- the FSM state typedef;
- the TIMEOUT default.
REQ-032 Load extraction and extension SHALL live in one combinational sub-module, load_extend (inputs: word, offset, funct3; output: result).

Verification
REQ-033 SB: addr=0x1003, wrdata=0x000000AB, ack on the first REQ cycle. Required: bus_addr=0x1000, bus_be=4'b1000, bus_wdata=0xAB000000, and stall high for 2 cycles.
REQ-034 LB: addr=0x2001, bus_rdata=0x0000F000. Required: read_data=0xFFFFFFF0. LBU with the same inputs: read_data=0x000000F0.
REQ-035 LH at addr=0x3001. Required: misalign=1 for one cycle, bus_req stays 0, stall=0.
REQ-036 LW with bus_ack held low. Required: stall high for TIMEOUT+2 cycles, a bus_err pulse, read_data=0.
REQ-037 Reset asserted on the 2nd REQ cycle of an SW. Required: bus_req=0 on the next cycle, state IDLE, no bus_err.
REQ-038 Back-to-back LW then SW with ack after 3 wait cycles each. Required: the second bus_req rises exactly one cycle after the first DONE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_pkg
//  Description : Shared definitions for the load/store unit: funct3 access
//                encodings, FSM state type/encodings, the default ack
//                timeout and a small alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    // Load encodings of funct3[2:0]
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // Store encodings of funct3[2:0]
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    // FSM state type and encodings
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_REQ  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    // Default number of wait cycles tolerated before bus_ack is declared lost
    localparam int c_TIMEOUT_DEFAULT = 255;

    // funct3[1:0] encodes the access size: 00 byte, 01 halfword, 1x word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (f3[1])
            bad = (off != 2'b00);
        else if (f3[0])
            bad = off[0];
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Combinational load data extraction. Shifts the bus word
//                right by the byte offset, then sign- or zero-extends the
//                selected byte/halfword according to funct3.
//  Ports       : word   - raw bus read word
//                offset - byte offset within the word
//                funct3 - access type (LB/LH/LW/LBU/LHU, others act as LW)
//                result - extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import load_store_unit_pkg::*;
#(
    parameter int V = 32
) (
    input  logic [V-1:0] word,
    input  logic [1:0]   offset,
    input  logic [2:0]   funct3,
    output logic [V-1:0] result
);

    logic [V-1:0] w_shifted;

    assign w_shifted = word >> {offset, 3'b000};

    always_comb begin
        result = w_shifted;
        case (funct3)
            c_F3_LB:  result = {{(V-8){w_shifted[7]}},   w_shifted[7:0]};
            c_F3_LH:  result = {{(V-16){w_shifted[15]}}, w_shifted[15:0]};
            c_F3_LBU: result = {{(V-8){1'b0}},           w_shifted[7:0]};
            c_F3_LHU: result = {{(V-16){1'b0}},          w_shifted[15:0]};
            default:  result = w_shifted;   // LW and the unused codes 011/110/111
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Bridges the CPU memory stage to a simple req/ack bus.
//                IDLE accepts an aligned load/store and registers a
//                word-aligned bus transaction, REQ holds it until bus_ack or
//                timeout, DONE presents the extended load result for one
//                cycle with stall released.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                mem_read_m, Mem_write_m - CPU load/store request
//                wrdata_add, wrdata      - byte address, right-aligned store data
//                funct_3m                - access type ([3] ignored)
//                read_data               - extended load result
//                stall, misalign, bus_err- pipeline control / status pulses
//                bus_*                   - bus master interface
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int V       = 32,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read_m,
    input  logic         Mem_write_m,
    input  logic [V-1:0] wrdata_add,
    input  logic [V-1:0] wrdata,
    input  logic [3:0]   funct_3m,
    output logic [V-1:0] read_data,
    output logic         stall,
    output logic         misalign,
    output logic         bus_err,
    output logic         bus_req,
    output logic         bus_we,
    output logic [V-1:0] bus_addr,
    output logic [V-1:0] bus_wdata,
    output logic [3:0]   bus_be,
    input  logic [V-1:0] bus_rdata,
    input  logic         bus_ack
);

    localparam int             CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  c_TO = CW'(TIMEOUT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [V-1:0]  addr_q,  addr_d;
    logic [1:0]    off_q,   off_d;
    logic [2:0]    f3_q,    f3_d;
    logic          we_q,    we_d;
    logic [V-1:0]  wdata_q, wdata_d;
    logic [3:0]    be_q,    be_d;
    logic          breq_q,  breq_d;
    logic [V-1:0]  rdata_q, rdata_d;
    logic          err_q,   err_d;

    // ------------------------------------------------------------------
    // Request decode in IDLE
    // ------------------------------------------------------------------
    logic          w_req;
    logic          w_misal;
    logic          w_accept;
    logic [1:0]    w_off;
    logic [2:0]    w_f3;
    logic [3:0]    w_be;
    logic [V-1:0]  w_wdata_sh;
    logic [V-1:0]  w_ld;
    logic          w_unused;

    assign w_req      = mem_read_m | Mem_write_m;
    assign w_off      = wrdata_add[1:0];
    assign w_f3       = funct_3m[2:0];
    assign w_misal    = is_misaligned(w_f3, w_off);
    assign w_accept   = (state_q == c_ST_IDLE) && w_req && !w_misal;
    assign w_wdata_sh = wrdata << {w_off, 3'b000};
    assign w_unused   = funct_3m[3];

    always_comb begin
        w_be = 4'b1111;
        if (w_f3[1:0] == c_F3_SB[1:0])
            w_be = 4'b0001 << w_off;
        else if (w_f3[1:0] == c_F3_SH[1:0])
            w_be = 4'b0011 << w_off;
    end

    // Extraction uses the offset/funct3 captured at accept time so the bus
    // word is interpreted against the access that is actually in flight.
    load_extend #(
        .V (V)
    ) u_load_extend (
        .word   (bus_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (w_ld)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        off_d   = off_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        breq_d  = breq_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    state_d = c_ST_REQ;
                    cnt_d   = '0;
                    addr_d  = {wrdata_add[V-1:2], 2'b00};
                    off_d   = w_off;
                    f3_d    = w_f3;
                    we_d    = Mem_write_m;   // store wins when both are high
                    wdata_d = w_wdata_sh;
                    be_d    = w_be;
                    breq_d  = 1'b1;
                end
            end
            c_ST_REQ: begin
                if (bus_ack) begin
                    state_d = c_ST_DONE;
                    breq_d  = 1'b0;
                    if (!we_q)
                        rdata_d = w_ld;
                end else if (cnt_q == c_TO) begin
                    state_d = c_ST_DONE;
                    breq_d  = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q)
                        rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
                breq_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            breq_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            breq_q  <= breq_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall     = w_accept || (state_q == c_ST_REQ);
    assign misalign  = (state_q == c_ST_IDLE) && w_req && w_misal;
    assign bus_err   = err_q;
    assign read_data = rdata_q;
    assign bus_req   = breq_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. Directed scenarios
//                plus randomized accesses compared against a byte-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int V  = 32;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_read_m = 1'b0;
    logic          Mem_write_m = 1'b0;
    logic [V-1:0]  wrdata_add = '0;
    logic [V-1:0]  wrdata = '0;
    logic [3:0]    funct_3m = 4'b0;
    logic [V-1:0]  read_data;
    logic          stall, misalign, bus_err, bus_req, bus_we;
    logic [V-1:0]  bus_addr, bus_wdata;
    logic [3:0]    bus_be;
    logic [V-1:0]  bus_rdata = '0;
    logic          bus_ack = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    logic [31:0] last_rd = '0;   // model of the read_data register

    load_store_unit #(.V(V), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mem_read_m(mem_read_m), .Mem_write_m(Mem_write_m),
        .wrdata_add(wrdata_add), .wrdata(wrdata), .funct_3m(funct_3m),
        .read_data(read_data), .stall(stall), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int nbytes(input logic [3:0] f3);
        if (f3[1]) return 4;
        if (f3[0]) return 2;
        return 1;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] a, input logic [3:0] f3);
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [3:0] f3);
        int m;
        m = ((1 << nbytes(f3)) - 1) * (1 << (a % 4));
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] a, input logic [31:0] d);
        longint unsigned v;
        v = longint'(d) * (longint'(1) << (8 * (a % 4)));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] f3,
                                               input logic [31:0] w);
        longint v;
        int n;
        n = nbytes(f3);
        if (n == 4) return w;
        v = (longint'(w) >> (8 * (a % 4))) % (longint'(1) << (8 * n));
        if (!f3[2] && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- protocol driver: returns observations only ----------------
    // Call just after a rising edge with the DUT idle; returns just after the
    // rising edge that ends the DONE cycle. ack_after<0 means never ack.
    task automatic drive_access(
        input  logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
        input  logic [3:0] f3, input int ack_after, input logic [31:0] rdata,
        output int n_stall, output int n_req, output logic [31:0] o_addr,
        output logic [31:0] o_wdata, output logic [3:0] o_be, output logic o_we,
        output logic stable, output logic [31:0] o_rd, output logic o_err,
        output logic done_ok, output int done_cyc, output int req_cyc);
        n_stall = 0; n_req = 0; stable = 1'b1; done_ok = 1'b0; o_err = 1'b0; o_rd = '0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0; done_cyc = 0; req_cyc = 0;
        mem_read_m = rd; Mem_write_m = wr; wrdata_add = addr; wrdata = data;
        funct_3m = f3; bus_ack = 1'b0; bus_rdata = rdata;
        @(negedge clk);
        if (stall) n_stall++;
        @(posedge clk); #1;
        mem_read_m = 1'b0; Mem_write_m = 1'b0;
        for (int c = 0; c < TO + 10 && !done_ok; c++) begin
            bus_ack = (ack_after >= 0) && (n_req == ack_after);
            @(negedge clk);
            if (stall) n_stall++;
            if (bus_req) begin
                if (n_req == 0) begin
                    o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
                    req_cyc = cyc_cnt;
                end else if (bus_addr !== o_addr || bus_wdata !== o_wdata ||
                             bus_be !== o_be || bus_we !== o_we) begin
                    stable = 1'b0;
                end
                n_req++;
            end else begin
                o_rd = read_data; o_err = bus_err; done_ok = 1'b1; done_cyc = cyc_cnt;
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({read_data, bus_req, bus_we, bus_be, bus_addr, bus_wdata, misalign, bus_err, stall} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%h req=%b we=%b be=%b addr=%h wd=%h mis=%b err=%b stall=%b, required all zero",
                     read_data, bus_req, bus_we, bus_be, bus_addr, bus_wdata, misalign, bus_err, stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = '0;
    endtask

    task automatic test_sb();
        int ns, nr, dc, rc; logic [31:0] a, wd, rd; logic [3:0] be; logic we, st, er, ok;
        drive_access(1'b0, 1'b1, 32'h1003, 32'h0000_00AB, 4'b0000, 0, 32'h0,
                     ns, nr, a, wd, be, we, st, rd, er, ok, dc, rc);
        checks++;
        if (a !== 32'h1000 || be !== 4'b1000 || wd !== 32'hAB00_0000 || we !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus: got addr=%h be=%b wdata=%h we=%b, required 00001000 1000 ab000000 1",
                     a, be, wd, we);
        end
        checks++;
        if (ns !== 2 || !ok) begin
            errors++;
            $display("FAIL sb_stall: got %0d cycles (done=%b), required 2", ns, ok);
        end
        checks++;
        if (rd !== last_rd) begin
            errors++;
            $display("FAIL sb_read_data: got %h, required unchanged %h", rd, last_rd);
        end
    endtask

    task automatic test_lb_lbu();
        int ns, nr, dc, rc; logic [31:0] a, wd, rd; logic [3:0] be; logic we, st, er, ok;
        drive_access(1'b1, 1'b0, 32'h2001, 32'h0, 4'b0000, 1, 32'h0000_F000,
                     ns, nr, a, wd, be, we, st, rd, er, ok, dc, rc);
        checks++;
        if (rd !== 32'hFFFF_FFF0 || a !== 32'h2000 || we !== 1'b0) begin
            errors++;
            $display("FAIL lb_data: got rd=%h addr=%h we=%b, required fffffff0 00002000 0", rd, a, we);
        end
        drive_access(1'b1, 1'b0, 32'h2001, 32'h0, 4'b0100, 0, 32'h0000_F000,
                     ns, nr, a, wd, be, we, st, rd, er, ok, dc, rc);
        checks++;
        if (rd !== 32'h0000_00F0) begin
            errors++;
            $display("FAIL lbu_data: got %h, required 000000f0", rd);
        end
        last_rd = 32'h0000_00F0;
    endtask

    task automatic test_misalign();
        mem_read_m = 1'b1; wrdata_add = 32'h3001; funct_3m = 4'b0001;
        @(negedge clk);
        checks++;
        if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_flag: got mis=%b stall=%b req=%b, required 1 0 0", misalign, stall, bus_req);
        end
        @(posedge clk); #1;
        mem_read_m = 1'b0;
        @(negedge clk);
        checks++;
        if (misalign !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after: got mis=%b req=%b stall=%b, required 0 0 0", misalign, bus_req, stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int ns, nr, dc, rc; logic [31:0] a, wd, rd; logic [3:0] be; logic we, st, er, ok;
        drive_access(1'b1, 1'b0, 32'h5000, 32'h0, 4'b0010, -1, 32'h1234_5678,
                     ns, nr, a, wd, be, we, st, rd, er, ok, dc, rc);
        checks++;
        if (!ok || ns !== TO + 2) begin
            errors++;
            $display("FAIL timeout_stall: got %0d cycles (done=%b), required %0d", ns, ok, TO + 2);
        end
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL timeout_err: got err=%b rd=%h, required 1 00000000", er, rd);
        end
        last_rd = '0;
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got bus_err=%b one cycle later, required 0", bus_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int ns, nr, dc, rc; logic [31:0] a, wd, rd; logic [3:0] be; logic we, st, er, ok;
        Mem_write_m = 1'b1; wrdata_add = 32'h4000; wrdata = 32'hCAFE_F00D; funct_3m = 4'b0010;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        Mem_write_m = 1'b0;            // REQ cycle 1
        @(posedge clk); #1;
        reset = 1'b1;                  // REQ cycle 2
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_req: got bus_req=%b before reset edge, required 1", bus_req);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = '0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_after: got req=%b err=%b stall=%b rd=%h, required 0 0 0 00000000",
                     bus_req, bus_err, stall, read_data);
        end
        @(posedge clk); #1;
        // the FSM must be idle: a new access is accepted with minimum latency
        drive_access(1'b1, 1'b0, 32'h4004, 32'h0, 4'b0010, 0, 32'h0BAD_BEEF,
                     ns, nr, a, wd, be, we, st, rd, er, ok, dc, rc);
        checks++;
        if (ns !== 2 || er !== 1'b0 || rd !== 32'h0BAD_BEEF) begin
            errors++;
            $display("FAIL abort_recover: got stall=%0d err=%b rd=%h, required 2 0 0badbeef", ns, er, rd);
        end
        last_rd = 32'h0BAD_BEEF;
    endtask

    task automatic test_back_to_back();
        int ns1, nr1, dc1, rc1, ns2, nr2, dc2, rc2;
        logic [31:0] a, wd, rd; logic [3:0] be; logic we, st, er, ok1, ok2;
        logic [31:0] w1, d2;
        w1 = $urandom; d2 = $urandom;
        drive_access(1'b1, 1'b0, 32'h6000, 32'h0, 4'b0010, 3, w1,
                     ns1, nr1, a, wd, be, we, st, rd, er, ok1, dc1, rc1);
        checks++;
        if (rd !== w1 || ns1 !== 5 || nr1 !== 4) begin
            errors++;
            $display("FAIL b2b_lw: got rd=%h stall=%0d req=%0d, required %h 5 4", rd, ns1, nr1, w1);
        end
        last_rd = w1;
        drive_access(1'b0, 1'b1, 32'h6008, d2, 4'b0010, 3, 32'h0,
                     ns2, nr2, a, wd, be, we, st, rd, er, ok2, dc2, rc2);
        checks++;
        if (!ok1 || !ok2 || rc2 - dc1 !== 2) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles from DONE to next bus_req, required 2 (accept in the cycle after DONE)",
                     rc2 - dc1);
        end
        checks++;
        if (a !== 32'h6008 || wd !== d2 || be !== 4'b1111 || rd !== last_rd || !st) begin
            errors++;
            $display("FAIL b2b_sw: got addr=%h wd=%h be=%b rd=%h stable=%b, required 00006008 %h 1111 %h 1",
                     a, wd, be, rd, st, d2, last_rd);
        end
    endtask

    task automatic test_random();
        int ns, nr, dc, rc, waits; logic [31:0] a, wd, rd; logic [3:0] be; logic we, st, er, ok;
        logic [31:0] addr, data, word; logic [3:0] f3; logic r, w;
        for (int i = 0; i < 40; i++) begin
            f3 = 4'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                addr = addr - (addr % nbytes(f3));   // mostly aligned
            data = $urandom; word = $urandom; waits = $urandom_range(0, 4);
            r = 1'($urandom); w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            if (model_misaligned(addr, f3)) begin
                mem_read_m = r; Mem_write_m = w; wrdata_add = addr; funct_3m = f3;
                @(negedge clk);
                checks++;
                if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_misalign[%0d]: addr=%h f3=%h got mis=%b stall=%b req=%b, required 1 0 0",
                             i, addr, f3, misalign, stall, bus_req);
                end
                @(posedge clk); #1;
                mem_read_m = 1'b0; Mem_write_m = 1'b0;
            end else begin
                drive_access(r, w, addr, data, f3, waits, word,
                             ns, nr, a, wd, be, we, st, rd, er, ok, dc, rc);
                if (!w) last_rd = model_load(addr, f3, word);
                checks++;
                if (!ok || nr !== waits + 1 || ns !== waits + 2 || er !== 1'b0 || !st) begin
                    errors++;
                    $display("FAIL rand_timing[%0d]: got req=%0d stall=%0d err=%b stable=%b, required %0d %0d 0 1",
                             i, nr, ns, er, st, waits + 1, waits + 2);
                end
                checks++;
                if (a !== {addr[31:2], 2'b00} || we !== w || be !== model_be(addr, f3) ||
                    (w && wd !== model_wdata(addr, data))) begin
                    errors++;
                    $display("FAIL rand_bus[%0d]: addr=%h f3=%h got a=%h we=%b be=%b wd=%h, required a=%h we=%b be=%b wd=%h",
                             i, addr, f3, a, we, be, wd, {addr[31:2], 2'b00}, w, model_be(addr, f3),
                             model_wdata(addr, data));
                end
                checks++;
                if (rd !== last_rd) begin
                    errors++;
                    $display("FAIL rand_read_data[%0d]: addr=%h f3=%h we=%b got %h, required %h",
                             i, addr, f3, w, rd, last_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_lb_lbu();
        test_misalign();
        test_random();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
